warmboot_sequencer: RTL
=======================

// Module: warmboot_sequencer
// PURPOSE
// - Sits between tinyfpga_bootloader and the iCE40 SB_WARMBOOT primitive in the board top level.
// - Consumes the bootloader's boot request and drops the USB pull-up so the host sees a detach.
// - Waits out a detach interval, then drives warmboot image select and BOOT, in that order, so S1/S0 are stable before BOOT rises.
// - Optional idle auto-boot when no USB activity is seen for a programmable interval.
// PARAMETERS
// - DETACH_CYCLES    4800000  cycles pull-up held low before arming (100 ms @ 48 MHz); must be >= 1
// - AUTOBOOT_CYCLES  0        idle cycles before auto-boot; 0 disables auto-boot
// - DEFAULT_IMAGE    2'b01    warmboot image used by auto-boot
// - CNT_W            32       counter width; must hold max(DETACH_CYCLES, AUTOBOOT_CYCLES)
// PORTS
// - clk_48mhz     in   1  system clock (PLL output)
// - reset         in   1  synchronous, active-high reset
// - boot_req      in   1  boot request from bootloader; level or pulse, sampled each cycle
// - image_sel     in   2  warmboot image for boot_req; sampled on the accepting cycle
// - usb_activity  in   1  one-cycle strobe per USB packet seen; restarts idle timer
// - pu_en         out  1  USB D+ pull-up enable (to pin_pu)
// - wb_s1         out  1  SB_WARMBOOT S1
// - wb_s0         out  1  SB_WARMBOOT S0
// - wb_boot       out  1  SB_WARMBOOT BOOT
// - busy          out  1  high in any state other than RUN
// BEHAVIOUR
// - Interface: one clock, clk_48mhz; reset is synchronous and active-high, named reset.
// - Reset values: state=RUN, pu_en=1, wb_s1=0, wb_s0=0, wb_boot=0, busy=0, all counters=0, latched image=0.
// - All outputs are registered.
// - States: RUN -> DETACH -> ARM -> FIRE.
// - FIRE is terminal; only reset leaves it.
// - RUN:
//   - pu_en=1.
//   - If AUTOBOOT_CYCLES>0: idle counter increments each cycle; clears to 0 on usb_activity.
//   - boot_req=1 in cycle N: latch image_sel, clear counter, enter DETACH at N+1.
//   - Idle counter reaches AUTOBOOT_CYCLES-1 with no boot_req: latch DEFAULT_IMAGE, enter DETACH.
//   - boot_req and idle expiry in the same cycle: boot_req wins, image_sel is latched.
//   - usb_activity and idle expiry in the same cycle: activity wins; counter clears; no boot.
// - DETACH:
//   - pu_en=0 and busy=1 from the first DETACH cycle.
//   - Counter runs 0..DETACH_CYCLES-1; on the last count, enter ARM.
//   - DETACH lasts exactly DETACH_CYCLES cycles.
// - ARM:
//   - Exactly one cycle; wb_s1/wb_s0 = latched image; wb_boot=0.
// - FIRE:
//   - wb_s1/wb_s0 hold the latched image; wb_boot=1; pu_en=0.
//   - State is held until reset.
// - Request filtering:
//   - boot_req, image_sel and usb_activity are ignored outside RUN.
//   - The latched image never changes after leaving RUN.
// - Timing from boot_req in cycle N: pu_en=0 at N+1; wb_s valid at N+1+DETACH_CYCLES; wb_boot=1 at N+2+DETACH_CYCLES.
// - Reset mid-operation (DETACH/ARM/FIRE): next cycle RUN with all reset values; pu_en returns to 1.
// - Counters saturate, never wrap; CNT_W overflow is a parameter error.
// TESTING
// - Use DETACH_CYCLES=8 and AUTOBOOT_CYCLES=20 unless stated otherwise.
// - Reset then idle, AUTOBOOT_CYCLES=0, 1000 cycles -> pu_en=1, busy=0, wb_boot=0 throughout.
// - boot_req 1-cycle pulse at cycle 10, image_sel=2'b10
//   -> pu_en=0 at cycles 11..; wb_s1=1, wb_s0=0 at cycle 19; wb_boot=1 at cycle 20 and held.
// - Auto-boot with usb_activity strobes every 15 cycles -> never boots.
// - Auto-boot with strobes stopped at cycle 100 -> DETACH at cycle 121; wb_s=DEFAULT_IMAGE; wb_boot=1 at cycle 130.
// - boot_req (image_sel=2'b11) coincident with idle expiry -> latched image 2'b11, not DEFAULT_IMAGE.
// - boot_req at cycle 10, image_sel changed and boot_req re-pulsed during DETACH -> timing and image unchanged from the first request.
// - Reset asserted at cycle 14 (mid-DETACH) -> RUN at cycle 15, pu_en=1; a fresh boot_req then gives full DETACH_CYCLES again.
// - Reset asserted while in FIRE -> next cycle wb_boot=0, wb_s1/wb_s0=0, pu_en=1, busy=0.

Source files
------------

// File: rtl/warmboot_sequencer_if.sv
// rtl/warmboot_sequencer_if.sv - boot request / warmboot control bundle
//
// Purpose: groups the bootloader-facing request signals and the
// pull-up / SB_WARMBOOT control outputs of warmboot_sequencer.
//
// Signals:
//   boot_req      bootloader -> sequencer  boot request (level or pulse)
//   image_sel[1:0] bootloader -> sequencer warmboot image for boot_req
//   usb_activity  bootloader -> sequencer  one-cycle strobe per USB packet
//   pu_en         sequencer  -> board      USB D+ pull-up enable
//   wb_s1, wb_s0  sequencer  -> SB_WARMBOOT image select
//   wb_boot       sequencer  -> SB_WARMBOOT BOOT
//   busy          sequencer  -> board      high outside RUN
//
// Modports:
//   master  request side (bootloader / testbench)
//   slave   the sequencer itself
interface warmboot_sequencer_if;
  logic       boot_req;
  logic [1:0] image_sel;
  logic       usb_activity;
  logic       pu_en;
  logic       wb_s1;
  logic       wb_s0;
  logic       wb_boot;
  logic       busy;

  modport master (
    output boot_req, image_sel, usb_activity,
    input  pu_en, wb_s1, wb_s0, wb_boot, busy
  );

  modport slave (
    input  boot_req, image_sel, usb_activity,
    output pu_en, wb_s1, wb_s0, wb_boot, busy
  );
endinterface

// File: rtl/warmboot_sequencer.sv
// rtl/warmboot_sequencer.sv - USB detach then iCE40 warmboot sequencer
//
// Purpose: accepts a boot request (or an idle auto-boot), drops the USB
// pull-up so the host sees a detach, waits DETACH_CYCLES, presents the
// warmboot image on S1/S0 for one cycle and then raises BOOT, holding it
// until reset.
//
// Ports:
//   clk_48mhz  in   system clock
//   reset      in   synchronous, active-high reset
//   bus        slave modport of warmboot_sequencer_if
//                boot_req, image_sel, usb_activity in
//                pu_en, wb_s1, wb_s0, wb_boot, busy out (all registered)
module warmboot_sequencer #(
  parameter int unsigned DETACH_CYCLES   = 4800000,
  parameter int unsigned AUTOBOOT_CYCLES = 0,
  parameter logic [1:0]  DEFAULT_IMAGE   = 2'b01,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  warmboot_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DETACH = 2'd1,
    ST_ARM    = 2'd2,
    ST_FIRE   = 2'd3
  } state_e;

  localparam bit               AUTOBOOT_EN   = (AUTOBOOT_CYCLES != 0);
  localparam logic [CNT_W-1:0] DETACH_LAST   = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] AUTOBOOT_LAST =
    AUTOBOOT_EN ? CNT_W'(AUTOBOOT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;

  state_e           state_q, state_d;
  // One counter serves as the idle timer in RUN and the detach timer in
  // DETACH; it is cleared on the transition between them.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       image_q, image_d;
  logic             pu_en_q, pu_en_d;
  logic             busy_q, busy_d;
  logic [1:0]       wb_s_q, wb_s_d;
  logic             wb_boot_q, wb_boot_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    image_d = image_q;

    case (state_q)
      ST_RUN: begin
        // Priority: explicit request, then activity, then idle expiry.
        if (bus.boot_req) begin
          image_d = bus.image_sel;
          cnt_d   = '0;
          state_d = ST_DETACH;
        end else if (AUTOBOOT_EN) begin
          if (bus.usb_activity) begin
            cnt_d = '0;
          end else if (cnt_q == AUTOBOOT_LAST) begin
            image_d = DEFAULT_IMAGE;
            cnt_d   = '0;
            state_d = ST_DETACH;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      ST_DETACH: begin
        // Counter is 0 on the first DETACH cycle, so leaving on
        // DETACH_LAST gives exactly DETACH_CYCLES cycles here.
        if (cnt_q == DETACH_LAST) begin
          state_d = ST_ARM;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_ARM: begin
        state_d = ST_FIRE;
      end
      ST_FIRE: begin
        state_d = ST_FIRE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies
    // line up with the state they describe (pu_en drops with the first
    // DETACH cycle, S1/S0 appear with ARM, BOOT with FIRE).
    pu_en_d   = (state_d == ST_RUN);
    busy_d    = (state_d != ST_RUN);
    wb_s_d    = ((state_d == ST_ARM) || (state_d == ST_FIRE)) ? image_d : 2'b00;
    wb_boot_d = (state_d == ST_FIRE);
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      image_q   <= 2'b00;
      pu_en_q   <= 1'b1;
      busy_q    <= 1'b0;
      wb_s_q    <= 2'b00;
      wb_boot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      image_q   <= image_d;
      pu_en_q   <= pu_en_d;
      busy_q    <= busy_d;
      wb_s_q    <= wb_s_d;
      wb_boot_q <= wb_boot_d;
    end
  end

  assign bus.pu_en   = pu_en_q;
  assign bus.busy    = busy_q;
  assign bus.wb_s1   = wb_s_q[1];
  assign bus.wb_s0   = wb_s_q[0];
  assign bus.wb_boot = wb_boot_q;

endmodule
